ps2_dir_queue: RTL and testbench
================================

# ps2_dir_queue

Turns the PS/2 byte stream into a queue of legal snake direction commands, and owns the committed snake direction. Sits between the PS/2 byte receiver and the snake movement logic. It decodes the E0/F0 prefix protocol and drops illegal turns. It buffers several quick turns so that none is lost between movement ticks.

## Interface
Parameters:
- DEPTH, 4: direction FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high.
- code_valid  in  1  one-cycle strobe; code holds a newly received scan byte.
- code  in  8  scan code byte.
- clear  in  1  synchronous reinit of the snake; empties the queue and sets dir=3.
- step  in  1  one-cycle movement tick; pops one queued command if any.
- dir  out  2  committed direction: 0 up, 1 down, 2 left, 3 right.
- dir_changed  out  1  one-cycle pulse when dir took a new value from the queue.
- start  out  1  one-cycle pulse on make of space (29h).
- pending  out  $clog2(DEPTH)+1  number of queued commands.
- overflow  out  1  sticky; set when a legal command was dropped because the FIFO was full.

## Operation
- Prefix FSM, advances only on code_valid:
  - IDLE: E0 goes to EXT; F0 goes to BRK; 29 pulses start and stays in IDLE; any other byte is ignored.
  - EXT: F0 goes to EXT_BRK. 75/72/6B/74 is an arrow make (up/down/left/right) and returns to IDLE. Any other byte returns to IDLE.
  - BRK and EXT_BRK: the next byte is consumed and discarded, then IDLE. Break codes never enqueue.
- Reference direction ref = the FIFO tail entry if pending>0, else dir.
- An arrow make with direction d is enqueued only if d≠ref and d is not the opposite of ref. Opposite pairs: 0/1, 2/3. Typematic repeats are therefore dropped.
- Legal command with a full FIFO: dropped, overflow set.
- step with pending>0: head popped into dir, dir_changed pulses. step with pending=0: no effect, no pulse.
- Simultaneous push and pop: both take effect and pending is unchanged. ref uses pre-pop state; a popped head equal to tail gives the same answer.
- Priority: reset, then clear, then normal operation.
- clear:
  - Empties the FIFO, sets dir=3, returns the FSM to IDLE.
  - Does not clear overflow.
  - Suppresses start and dir_changed that cycle.
- All arithmetic on pointers wraps modulo DEPTH. pending saturates by construction (0..DEPTH).

## Timing
- Reset values: dir=3, dir_changed=0, start=0, pending=0, overflow=0, FSM=IDLE, pointers 0.
- Final arrow byte with code_valid at cycle N: pending increments at N+1.
- step at cycle M: dir and dir_changed valid at M+1. dir_changed lasts exactly one cycle.
- A command enqueued at N can be popped by step at N+1 or later, not at N.
- code 29 at N: start high in cycle N+1 only.
- code_valid is assumed to come at most once per cycle; back-to-back strobes on consecutive cycles are supported.
- reset or clear mid-sequence: partial prefixes are discarded. For example, E0 then clear then 75 yields no command, because 75 is seen in IDLE.

## Structure
- snake_pkg holds:
  - direction constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3;
  - scan code constants (E0, F0, 75, 72, 6B, 74, 29);
  - the FSM state encoding;
  - an opposite(d) function (d xor 1).
- Sub-module dir_fifo: DEPTH×2-bit synchronous FIFO with push, pop, flush, count and tail outputs. The top block contains the FSM, the legality check, and the dir/pulse registers.

## Test plan
- Reset, then E0 75 → pending=1. step → dir=0 one cycle later, dir_changed pulses once.
- dir=3, bytes E0 6B (left, reverse) → pending stays 0, overflow=0. Then E0 75, E0 72 → only up is queued (down is the reverse of tail up), pending=1.
- DEPTH=4, alternating legal turns E0 75, E0 74, E0 72, E0 6B, E0 75 with no step → pending=4, overflow=1 after the fifth. Four steps → dir sequence 0, 3, 1, 2.
- E0 F0 75 and F0 29 → no enqueue, no start. 29 alone → start high for exactly one cycle.
- Queue holding 2 entries, step and an arrow byte in the same cycle → pending stays 2 and dir updates correctly.
- E0, then clear, then 75 → pending=0, dir=3, FSM back in IDLE. overflow is retained across clear and cleared only by reset.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants for the snake direction path: directions, PS/2 scan
// codes, prefix-decoder state encoding and the opposite-direction helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Up/down and left/right differ only in the LSB.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of 2-bit direction commands. Exposes both the head
// (next command to commit) and the tail (most recently queued command).
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [1:0]               din,
  output logic [1:0]               head,
  output logic [1:0]               tail,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] last_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && (count != FULL_COUNT) && !flush;
  assign do_pop   = pop && (count != '0) && !flush;
  assign last_ptr = wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[last_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_dir_queue.sv
// PS/2 scan stream to snake direction queue. Decodes E0/F0 prefixes, drops
// reversals and repeats against the latest intended direction, buffers
// turns until movement ticks, and holds the committed direction.
module ps2_dir_queue
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   code_valid,
  input  logic [7:0]             code,
  input  logic                   clear,
  input  logic                   step,
  output logic [1:0]             dir,
  output logic                   dir_changed,
  output logic                   start,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [1:0] dir_reg;
  logic       dir_changed_reg;
  logic       start_reg;
  logic       overflow_reg;

  logic       arrow_make;
  logic [1:0] arrow_dir;
  logic [1:0] ref_dir;
  logic       legal;
  logic       fifo_push;
  logic       fifo_pop;
  logic [1:0] fifo_head;
  logic [1:0] fifo_tail;

  // Prefix decoder next state and arrow-make detection.
  always_comb begin
    state_next = state_reg;
    arrow_make = 1'b0;
    arrow_dir  = DIR_UP;
    if (code_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (code == SC_EXT)      state_next = ST_EXT;
          else if (code == SC_BRK) state_next = ST_BRK;
        end
        ST_EXT: begin
          state_next = ST_IDLE;
          case (code)
            SC_BRK:   state_next = ST_EXT_BRK;
            SC_UP:    begin arrow_make = 1'b1; arrow_dir = DIR_UP;    end
            SC_DOWN:  begin arrow_make = 1'b1; arrow_dir = DIR_DOWN;  end
            SC_LEFT:  begin arrow_make = 1'b1; arrow_dir = DIR_LEFT;  end
            SC_RIGHT: begin arrow_make = 1'b1; arrow_dir = DIR_RIGHT; end
            default:  state_next = ST_IDLE;
          endcase
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Turns are judged against the last queued intent, not the committed dir.
  assign ref_dir   = (pending != '0) ? fifo_tail : dir_reg;
  assign legal     = arrow_make && (arrow_dir != ref_dir) &&
                     (arrow_dir != opposite(ref_dir)) && !clear;
  assign fifo_push = legal && (pending != FULL_COUNT);
  assign fifo_pop  = step && (pending != '0) && !clear;

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (clear),
    .din   (arrow_dir),
    .head  (fifo_head),
    .tail  (fifo_tail),
    .count (pending)
  );

  // Prefix FSM, committed direction, pulses and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      dir_reg         <= DIR_RIGHT;
      dir_changed_reg <= 1'b0;
      start_reg       <= 1'b0;
      overflow_reg    <= 1'b0;
    end else if (clear) begin
      state_reg       <= ST_IDLE;
      dir_reg         <= DIR_RIGHT;
      dir_changed_reg <= 1'b0;
      start_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dir_changed_reg <= fifo_pop;
      start_reg       <= code_valid && (state_reg == ST_IDLE) && (code == SC_SPACE);
      if (fifo_pop) dir_reg <= fifo_head;
      if (legal && (pending == FULL_COUNT)) overflow_reg <= 1'b1;
    end
  end

  assign dir         = dir_reg;
  assign dir_changed = dir_changed_reg;
  assign start       = start_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ps2_dir_queue.sv
// Self-checking bench for ps2_dir_queue: directed scenarios plus a random
// byte/step/clear stream compared against a queue-based reference model.
module tb_ps2_dir_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       clear = 1'b0;
  logic       step = 1'b0;
  logic [1:0] dir;
  logic       dir_changed;
  logic       start;
  logic [2:0] pending;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_q[$];
  int m_dir = 3;
  bit m_changed = 0;
  bit m_start = 0;
  bit m_over = 0;
  int m_mode = 0;  // 0 plain, 1 after E0, 2 discard next byte

  always #5 clk = ~clk;

  ps2_dir_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code        (code),
    .clear       (clear),
    .step        (step),
    .dir         (dir),
    .dir_changed (dir_changed),
    .start       (start),
    .pending     (pending),
    .overflow    (overflow)
  );

  function automatic int arrow_of(input logic [7:0] c);
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  // Apply one clock of the behavioural rules to the model.
  task automatic model_clock(input bit r, input bit v, input logic [7:0] c,
                             input bit s, input bit cl);
    int d, rf, nd;
    bit do_pop;
    if (r) begin
      m_q.delete(); m_dir = 3; m_changed = 0; m_start = 0; m_over = 0; m_mode = 0;
      return;
    end
    if (cl) begin
      m_q.delete(); m_dir = 3; m_changed = 0; m_start = 0; m_mode = 0;
      return;
    end
    m_start = 0;
    rf = (m_q.size() > 0) ? m_q[$] : m_dir;
    do_pop = s && (m_q.size() > 0);
    nd = do_pop ? m_q[0] : m_dir;
    d = -1;
    if (v) begin
      if (m_mode == 2) m_mode = 0;
      else if (m_mode == 1) begin
        if (c == 8'hF0) m_mode = 2;
        else begin m_mode = 0; d = arrow_of(c); end
      end else begin
        if (c == 8'hE0) m_mode = 1;
        else if (c == 8'hF0) m_mode = 2;
        else if (c == 8'h29) m_start = 1;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (d >= 0 && d != rf && d != (rf ^ 1)) begin
      if (m_q.size() + (do_pop ? 1 : 0) >= DEPTH) m_over = 1;
      else m_q.push_back(d);
    end
    m_changed = do_pop;
    m_dir = nd;
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic drive(input bit r, input bit v, input logic [7:0] c,
                       input bit s, input bit cl);
    reset = r; code_valid = v; code = c; step = s; clear = cl;
    @(posedge clk);
    model_clock(r, v, c, s, cl);
    #1;
    reset = 0; code_valid = 0; code = 8'h00; step = 0; clear = 0;
  endtask

  task automatic send(input logic [7:0] c);
    drive(0, 1, c, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (dir !== 2'd3) begin fails++; $display("FAIL reset_dir got=%0d exp=3", dir); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    tests++; if ({dir_changed, start, overflow} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got=%b exp=000", {dir_changed, start, overflow}); end
  endtask

  task automatic test_basic();
    do_reset();
    send(8'hE0); send(8'h75);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL basic_pending got=%0d exp=1", pending); end
    drive(0, 0, 8'h00, 1, 0);
    tests++; if (dir !== 2'd0 || dir_changed !== 1'b1) begin
      fails++; $display("FAIL basic_step got dir=%0d chg=%b exp dir=0 chg=1", dir, dir_changed); end
    drive(0, 0, 8'h00, 0, 0);
    tests++; if (dir_changed !== 1'b0 || pending !== 3'd0) begin
      fails++; $display("FAIL basic_pulse got chg=%b pend=%0d exp chg=0 pend=0", dir_changed, pending); end
  endtask

  task automatic test_reverse();
    do_reset();
    send(8'hE0); send(8'h6B);
    tests++; if (pending !== 3'd0 || overflow !== 1'b0) begin
      fails++; $display("FAIL reverse_drop got pend=%0d ovf=%b exp 0 0", pending, overflow); end
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL reverse_tail got=%0d exp=1", pending); end
  endtask

  task automatic test_overflow();
    logic [7:0] seq [5] = '{8'h75, 8'h74, 8'h72, 8'h6B, 8'h75};
    int exp_dirs [4] = '{0, 3, 1, 2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'hE0); send(seq[i]);
      if (i == 3) begin
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    tests++; if (pending !== 3'd4 || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_full got pend=%0d ovf=%b exp 4 1", pending, overflow); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      tests++; if (dir !== 2'(exp_dirs[i]) || dir_changed !== 1'b1) begin
        fails++; $display("FAIL ovf_pop%0d got dir=%0d chg=%b exp dir=%0d chg=1", i, dir, dir_changed, exp_dirs[i]); end
    end
    drive(0, 0, 8'h00, 1, 0);
    tests++; if (dir_changed !== 1'b0 || dir !== 2'd2) begin
      fails++; $display("FAIL ovf_empty_step got dir=%0d chg=%b exp dir=2 chg=0", dir, dir_changed); end
  endtask

  task automatic test_break_start();
    do_reset();
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h29);
    tests++; if (pending !== 3'd0 || start !== 1'b0) begin
      fails++; $display("FAIL break_noeffect got pend=%0d start=%b exp 0 0", pending, start); end
    send(8'h29);
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL start_pulse got=%b exp=1", start); end
    drive(0, 0, 8'h00, 0, 0);
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL start_len got=%b exp=0", start); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h74);
    send(8'hE0);
    drive(0, 1, 8'h72, 1, 0);
    tests++; if (pending !== 3'd2 || dir !== 2'd0 || dir_changed !== 1'b1) begin
      fails++; $display("FAIL simul got pend=%0d dir=%0d chg=%b exp 2 0 1", pending, dir, dir_changed); end
    drive(0, 0, 8'h00, 1, 0);
    drive(0, 0, 8'h00, 1, 0);
    tests++; if (dir !== 2'd1) begin fails++; $display("FAIL simul_tail got=%0d exp=1", dir); end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); send(8'hE0); send(8'h74); end
    send(8'hE0);
    drive(0, 0, 8'h00, 0, 1);
    send(8'h75);
    tests++; if (pending !== 3'd0 || dir !== 2'd3 || overflow !== 1'b1) begin
      fails++; $display("FAIL clear got pend=%0d dir=%0d ovf=%b exp 0 3 1", pending, dir, overflow); end
    send(8'hE0); send(8'h75);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL clear_idle got=%0d exp=1", pending); end
    do_reset();
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_reset got=%b exp=0", overflow); end
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h1C};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit v, s, cl;
      logic [7:0] c;
      v  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 4) == 0);
      cl = ($urandom_range(0, 60) == 0);
      c  = pool[$urandom_range(0, 7)];
      drive(0, v, c, s, cl);
      tests++;
      if (dir !== 2'(m_dir) || dir_changed !== m_changed || start !== m_start ||
          pending !== 3'(m_q.size()) || overflow !== m_over) begin
        fails++;
        $display("FAIL random%0d got dir=%0d chg=%b st=%b pend=%0d ovf=%b exp dir=%0d chg=%b st=%b pend=%0d ovf=%b",
                 i, dir, dir_changed, start, pending, overflow,
                 m_dir, m_changed, m_start, m_q.size(), m_over);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_overflow();
    test_break_start();
    test_back_to_back();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
